// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Per-channel synchronizer, tick-sampled debouncer and press-edge
//               pulse generator for raw push-button inputs. Define the macro
//               AUTOREPEAT_EN to add held-button auto-repeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150,
    parameter int REPEAT_TICKS   = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_level,
    output logic [WIDTH-1:0] btn_pulse
);

    localparam int c_SAMPLE_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int c_DB_W     = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [c_SAMPLE_W-1:0] c_SAMPLE_LAST = c_SAMPLE_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_DB_W-1:0]     c_PULSE_MAX   = c_DB_W'(PULSE_CNT_MAX);

`ifdef AUTOREPEAT_EN
    localparam int c_REP_W = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_TICKS - 1);
`endif

    logic [WIDTH-1:0]      r_sync_meta;
    logic [WIDTH-1:0]      r_sync;
    logic [c_SAMPLE_W-1:0] r_sample_cnt;
    logic                  w_tick;
    logic [WIDTH-1:0]      r_level_q;
    logic [WIDTH-1:0]      r_pulse;
    logic [WIDTH-1:0]      w_repeat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= btn_in;
            r_sync      <= r_sync_meta;
        end
    end

    // Shared free-running sample timebase; a single-cycle period ticks every cycle.
    assign w_tick = (r_sample_cnt == c_SAMPLE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample_cnt <= '0;
        end else if (w_tick) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chan
            logic [c_DB_W-1:0] r_db_cnt;

            // Any low synchronized sample restarts qualification immediately.
            always_ff @(posedge clk) begin
                if (rst || !r_sync[i]) begin
                    r_db_cnt <= '0;
                end else if (w_tick && (r_db_cnt != c_PULSE_MAX)) begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end

            assign btn_level[i] = (r_db_cnt == c_PULSE_MAX);

`ifdef AUTOREPEAT_EN
            logic [c_REP_W-1:0] r_rep_cnt;

            always_ff @(posedge clk) begin
                if (rst || !btn_level[i]) begin
                    r_rep_cnt <= '0;
                end else if (w_tick) begin
                    r_rep_cnt <= (r_rep_cnt == c_REP_LAST) ? '0 : r_rep_cnt + 1'b1;
                end
            end

            // Requiring the level to have been high last cycle keeps repeats off the initial pulse.
            assign w_repeat[i] = btn_level[i] & r_level_q[i] & w_tick & (r_rep_cnt == c_REP_LAST);
`else
            // Repeat disabled: any legal REPEAT_TICKS (>=1) ties this to zero.
            assign w_repeat[i] = (REPEAT_TICKS < 1);
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_q <= '0;
            r_pulse   <= '0;
        end else begin
            r_level_q <= btn_level;
            r_pulse   <= (btn_level & ~r_level_q) | w_repeat;
        end
    end

    assign btn_pulse = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed, table-driven self-checking bench for button_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int WIDTH          = 2;
    localparam int SAMPLE_CNT_MAX = 4;
    localparam int PULSE_CNT_MAX  = 3;
    localparam int REPEAT_TICKS   = 2;

`ifdef AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    localparam logic [1:0] RP11 = AR ? 2'b11 : 2'b00;
    localparam logic [1:0] RP01 = AR ? 2'b01 : 2'b00;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] btn_in;
    logic [WIDTH-1:0] btn_level;
    logic [WIDTH-1:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [1:0] btn;
        logic [1:0] lvl;
        logic [1:0] pls;
    } vec_t;

    vec_t tbl[$];

    button_conditioner #(
        .WIDTH          (WIDTH),
        .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
        .PULSE_CNT_MAX  (PULSE_CNT_MAX),
        .REPEAT_TICKS   (REPEAT_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [1:0] b, input logic [1:0] l,
                       input logic [1:0] p, input int n);
        vec_t v;
        v.rst = r;
        v.btn = b;
        v.lvl = l;
        v.pls = p;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 2'b11;

        // Entry k = inputs before edge k, outputs just after edge k (edge 1 is the first edge).
        // Sample ticks land on edges 6, 10, 14, ... after this reset.
        add(1'b1, 2'b11, 2'b00, 2'b00, 2);   // edges 1-2: in reset
        add(1'b0, 2'b11, 2'b00, 2'b00, 11);  // 3-13: qualifying
        add(1'b0, 2'b11, 2'b11, 2'b00, 1);   // 14: level rises
        add(1'b0, 2'b11, 2'b11, 2'b11, 1);   // 15: simultaneous pulses
        add(1'b0, 2'b11, 2'b11, 2'b00, 5);   // 16-20
        add(1'b0, 2'b00, 2'b11, 2'b00, 1);   // 21: release in flight
        add(1'b0, 2'b00, 2'b11, RP11,  1);   // 22
        add(1'b0, 2'b00, 2'b00, 2'b00, 4);   // 23-26: level fell 3 cycles after release
        add(1'b0, 2'b01, 2'b00, 2'b00, 11);  // 27-37: clean press on ch0
        add(1'b0, 2'b01, 2'b01, 2'b00, 1);   // 38
        add(1'b0, 2'b01, 2'b01, 2'b01, 1);   // 39: second press pulse
        add(1'b0, 2'b01, 2'b01, 2'b00, 6);   // 40-45
        add(1'b0, 2'b01, 2'b01, RP01,  1);   // 46
        add(1'b0, 2'b01, 2'b01, 2'b00, 7);   // 47-53
        add(1'b0, 2'b01, 2'b01, RP01,  1);   // 54
        add(1'b0, 2'b01, 2'b01, 2'b00, 7);   // 55-61
        add(1'b0, 2'b01, 2'b01, RP01,  1);   // 62
        add(1'b0, 2'b01, 2'b01, 2'b00, 4);   // 63-66
        add(1'b0, 2'b00, 2'b01, 2'b00, 2);   // 67-68
        add(1'b0, 2'b00, 2'b00, 2'b00, 4);   // 69-72: no release pulse
        add(1'b0, 2'b01, 2'b00, 2'b00, 5);   // 73-77: bounce
        add(1'b0, 2'b00, 2'b00, 2'b00, 1);   // 78
        add(1'b0, 2'b01, 2'b00, 2'b00, 5);   // 79-83
        add(1'b0, 2'b00, 2'b00, 2'b00, 7);   // 84-90
        add(1'b0, 2'b10, 2'b00, 2'b00, 11);  // 91-101: ch1 alone
        add(1'b0, 2'b10, 2'b10, 2'b00, 1);   // 102
        add(1'b0, 2'b10, 2'b10, 2'b10, 1);   // 103
        add(1'b0, 2'b10, 2'b10, 2'b00, 3);   // 104-106
        add(1'b0, 2'b00, 2'b10, 2'b00, 2);   // 107-108
        add(1'b0, 2'b00, 2'b00, 2'b00, 4);   // 109-112

        for (int k = 0; k < tbl.size(); k++) begin
            rst    = tbl[k].rst;
            btn_in = tbl[k].btn;
            step();
            check($sformatf("tbl[%0d].level", k + 1), btn_level, tbl[k].lvl);
            check($sformatf("tbl[%0d].pulse", k + 1), btn_pulse, tbl[k].pls);
        end

        // Reset while a qualified press is held.
        rst    = 1'b1;
        btn_in = 2'b01;
        step();
        check("mid_arm.level", btn_level, 2'b00);
        rst = 1'b0;
        repeat (16) step();
        check("mid_held.level", btn_level, 2'b01);
        rst = 1'b1;
        step();
        check("mid_rst.level", btn_level, 2'b00);
        check("mid_rst.pulse", btn_pulse, 2'b00);
        rst = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("mid_req[%0d].level", k), btn_level, (k >= 12) ? 2'b01 : 2'b00);
            check($sformatf("mid_req[%0d].pulse", k), btn_pulse, (k == 13) ? 2'b01 : 2'b00);
        end
        btn_in = 2'b00;
        repeat (4) step();

        // Long hold: one pulse, plus repeats every 8 cycles when auto-repeat is built in.
        rst    = 1'b1;
        btn_in = 2'b00;
        step();
        rst    = 1'b0;
        btn_in = 2'b01;
        for (int k = 1; k <= 70; k++) begin
            logic [1:0] exp_p;
            if (k == 61) btn_in = 2'b00;
            step();
            exp_p = ((k == 13) || (AR && k >= 20 && k <= 60 && ((k - 20) % 8) == 0)) ? 2'b01 : 2'b00;
            check($sformatf("hold[%0d].level", k), btn_level, (k >= 12 && k <= 62) ? 2'b01 : 2'b00);
            check($sformatf("hold[%0d].pulse", k), btn_pulse, exp_p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
